dht11_emulador: RTL

DHT11_EMULADOR -- requirements
Module: dht11_emulador

---
 rtl/dht11_pkg.sv | 30 +++
 rtl/dht11_emulador_if.sv | 20 ++
 rtl/dht11_tick_us.sv | 30 +++
 rtl/dht11_emulador.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/dht11_pkg.sv
// Shared DHT11 protocol definitions: state encodings, phase durations in microseconds
// and the frame checksum. Used by both the sensor emulator and the dht11 host.
package dht11_pkg;

  typedef enum logic [3:0] {
    OCIOSO         = 4'd0,
    MEDE_START     = 4'd1,
    ESPERA_SOLTURA = 4'd2,
    ATRASO         = 4'd3,
    RESP_BAIXO     = 4'd4,
    RESP_ALTO      = 4'd5,
    BIT_BAIXO      = 4'd6,
    BIT_ALTO       = 4'd7,
    FIM_BAIXO      = 4'd8
  } dht11_estado_t;

  localparam int T_ATRASO_US    = 30;
  localparam int T_RESP_US      = 80;
  localparam int T_BIT_BAIXO_US = 50;
  localparam int T_BIT_ZERO_US  = 26;
  localparam int T_BIT_UM_US    = 70;
  localparam int T_FIM_US       = 50;
  localparam int N_BITS         = 40;

  // Sum of the four data bytes; the carry out of bit 7 is dropped.
  function automatic logic [7:0] dht11_checksum(input logic [15:0] umid, input logic [15:0] temp);
    return umid[15:8] + umid[7:0] + temp[15:8] + temp[7:0];
  endfunction

endpackage

// File: rtl/dht11_emulador_if.sv
// Bundle of the emulator's data and status signals. The injeta_erro signal is only
// wired to the emulator when DHT11_EMULADOR_ERRO_EN is defined.
interface dht11_emulador_if;
  logic [15:0] umidade;
  logic [15:0] temperatura;
  logic        injeta_erro;
  logic        ocupado;
  logic        enviado;
  logic [3:0]  db_estado;

  modport master (
    output umidade, temperatura, injeta_erro,
    input  ocupado, enviado, db_estado
  );

  modport slave (
    input  umidade, temperatura, injeta_erro,
    output ocupado, enviado, db_estado
  );
endinterface

// File: rtl/dht11_tick_us.sv
// One-cycle pulse every microsecond, derived by dividing the system clock
// by CLK_FREQ_HZ/1000000.
module dht11_tick_us #(
  parameter int CLK_FREQ_HZ = 50000000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int DIV = CLK_FREQ_HZ / 1000000;
  localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/dht11_emulador.sv
// DHT11 sensor emulator: detects the host start pulse and answers with a 40-bit frame.
// Optional macro DHT11_EMULADOR_ERRO_EN adds injeta_erro to corrupt the checksum.
module dht11_emulador
  import dht11_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50000000,
  parameter int START_MIN_US = 18000
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire         dht_bus,
  input  logic [15:0] umidade,
  input  logic [15:0] temperatura,
`ifdef DHT11_EMULADOR_ERRO_EN
  input  logic        injeta_erro,
`endif
  output logic        ocupado,
  output logic        enviado,
  output logic [3:0]  db_estado
);

  localparam logic [15:0] START_LIM = 16'(START_MIN_US);
  localparam logic [15:0] D_ATRASO  = 16'(T_ATRASO_US - 1);
  localparam logic [15:0] D_RESP    = 16'(T_RESP_US - 1);
  localparam logic [15:0] D_BAIXO   = 16'(T_BIT_BAIXO_US - 1);
  localparam logic [15:0] D_ZERO    = 16'(T_BIT_ZERO_US - 1);
  localparam logic [15:0] D_UM      = 16'(T_BIT_UM_US - 1);
  localparam logic [15:0] D_FIM     = 16'(T_FIM_US - 1);
  localparam logic [5:0]  LAST_BIT  = 6'(N_BITS - 1);

  dht11_estado_t state, state_n;
  logic [15:0] cnt, cnt_n, dur_last;
  logic [5:0]  bit_cnt, bit_n;
  logic [39:0] frame, frame_n, frame_lat;
  logic [7:0]  soma, soma_env;
  logic        tick, timer_done, timed;
  logic        bus_meta, bus_sync, bus_prev;
  logic        drive_low, eco1, eco2;

  dht11_tick_us #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  assign soma = dht11_checksum(umidade, temperatura);
`ifdef DHT11_EMULADOR_ERRO_EN
  assign soma_env = injeta_erro ? ~soma : soma;
`else
  assign soma_env = soma;
`endif
  assign frame_lat = {umidade, temperatura, soma_env};

  // eco1/eco2 track our own drive through the same two-flop delay as the synchronizer,
  // so the tail of FIM_BAIXO still in the pipeline is not mistaken for a new start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus_meta <= 1'b1;
      bus_sync <= 1'b1;
      bus_prev <= 1'b1;
      eco1     <= 1'b0;
      eco2     <= 1'b0;
    end else begin
      bus_meta <= dht_bus;
      bus_sync <= bus_meta;
      bus_prev <= bus_sync;
      eco1     <= drive_low;
      eco2     <= eco1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= OCIOSO;
      cnt       <= '0;
      bit_cnt   <= '0;
      frame     <= '0;
      drive_low <= 1'b0;
      enviado   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_cnt   <= bit_n;
      frame     <= frame_n;
      drive_low <= (state_n == RESP_BAIXO) || (state_n == BIT_BAIXO) || (state_n == FIM_BAIXO);
      enviado   <= (state == FIM_BAIXO) && (state_n == OCIOSO);
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bit_n    = bit_cnt;
    frame_n  = frame;
    dur_last = '0;
    timed    = 1'b1;

    unique case (state)
      ATRASO:     dur_last = D_ATRASO;
      RESP_BAIXO: dur_last = D_RESP;
      RESP_ALTO:  dur_last = D_RESP;
      BIT_BAIXO:  dur_last = D_BAIXO;
      BIT_ALTO:   dur_last = frame[N_BITS-1] ? D_UM : D_ZERO;
      FIM_BAIXO:  dur_last = D_FIM;
      default:    timed    = 1'b0;
    endcase
    timer_done = timed && tick && (cnt == dur_last);

    if (timed) begin
      if (timer_done)
        cnt_n = '0;
      else if (tick)
        cnt_n = cnt + 16'd1;
    end

    unique case (state)
      OCIOSO: begin
        cnt_n = '0;
        if (!bus_sync && !eco2)
          state_n = MEDE_START;
      end
      MEDE_START: begin
        if (bus_sync) begin
          state_n = OCIOSO;
          cnt_n   = '0;
        end else if (cnt >= START_LIM) begin
          state_n = ESPERA_SOLTURA;
        end else if (tick) begin
          cnt_n = cnt + 16'd1;
        end
      end
      ESPERA_SOLTURA: begin
        cnt_n = '0;
        if (bus_sync && !bus_prev) begin
          state_n = ATRASO;
          frame_n = frame_lat;
          bit_n   = '0;
        end
      end
      ATRASO:     if (timer_done) state_n = RESP_BAIXO;
      RESP_BAIXO: if (timer_done) state_n = RESP_ALTO;
      RESP_ALTO:  if (timer_done) state_n = BIT_BAIXO;
      BIT_BAIXO:  if (timer_done) state_n = BIT_ALTO;
      BIT_ALTO: begin
        if (timer_done) begin
          if (bit_cnt == LAST_BIT) begin
            state_n = FIM_BAIXO;
          end else begin
            state_n = BIT_BAIXO;
            bit_n   = bit_cnt + 6'd1;
            frame_n = {frame[N_BITS-2:0], 1'b0};
          end
        end
      end
      FIM_BAIXO: begin
        if (timer_done) begin
          state_n = OCIOSO;
          bit_n   = '0;
        end
      end
      default: state_n = OCIOSO;
    endcase
  end

  assign dht_bus   = drive_low ? 1'b0 : 1'bz;
  assign ocupado   = (state >= ATRASO) && (state <= FIM_BAIXO);
  assign db_estado = state;

endmodule
